// File: rtl/letc_core_pkg.sv
// Shared types for the core data-memory path: load/store unit size codes,
// FSM states and the request record latched at acceptance.
package letc_core_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE,
    LD_ISSUE,
    LD_WAIT,
    RESP,
    ST_ISSUE
  } lsu_state_e;

  typedef struct packed {
    logic        is_store;
    lsu_size_e   size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // The DMSS only ever sees word-aligned addresses; lanes are picked by byte enables.
  function automatic logic [31:0] lsu_word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/letc_core_lsu_if.sv
// Request/response handshake between the memory stage and the LSU, plus the
// LSU's DMSS load/store port. master = core + DMSS side, slave = LSU.
interface letc_core_lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_misaligned;

  logic        dmss_load_valid;
  logic [31:0] dmss_load_addr;
  logic [31:0] dmss_load_data;

  logic        dmss_store_valid;
  logic [31:0] dmss_store_addr;
  logic [31:0] dmss_store_data;
  logic [3:0]  dmss_store_be;

  modport master (
    output req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_misaligned,
    input  dmss_load_valid, dmss_load_addr,
    output dmss_load_data,
    input  dmss_store_valid, dmss_store_addr, dmss_store_data, dmss_store_be
  );

  modport slave (
    input  req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_data, rsp_misaligned,
    output dmss_load_valid, dmss_load_addr,
    input  dmss_load_data,
    output dmss_store_valid, dmss_store_addr, dmss_store_data, dmss_store_be
  );

endinterface

// File: rtl/letc_core_lsu_align.sv
// Combinational lane logic for the LSU: store data/byte-enable placement,
// load byte/half extraction with sign or zero extension, and misalignment.
module letc_core_lsu_align
  import letc_core_pkg::*;
(
  input  lsu_size_e   size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] load_word,
  output logic [31:0] store_data,
  output logic [3:0]  store_be,
  output logic [31:0] load_result,
  output logic        misaligned
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign load_byte = load_word[{offset, 3'b000} +: 8];
  assign load_half = offset[1] ? load_word[31:16] : load_word[15:0];

  // Place store data and enables on the lanes selected by the offset, and extend loads.
  always_comb begin
    store_data  = wdata << {offset, 3'b000};
    store_be    = 4'b0000;
    load_result = load_word;
    misaligned  = 1'b0;
    unique case (size)
      BYTE: begin
        store_be    = 4'b0001 << offset;
        load_result = {{24{~is_unsigned & load_byte[7]}}, load_byte};
      end
      HALF: begin
        store_be    = 4'b0011 << offset;
        misaligned  = offset[0];
        load_result = {{16{~is_unsigned & load_half[15]}}, load_half};
      end
      WORD: begin
        store_be    = 4'b1111;
        misaligned  = (offset != 2'b00);
      end
      RSVD: begin
        misaligned  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/letc_core_lsu.sv
// Load/store unit: accepts one request at a time, faults misaligned accesses
// without touching memory, issues word-aligned DMSS accesses and returns a
// single-cycle response. Loads wait a fixed LOAD_LATENCY before capture.
module letc_core_lsu
  import letc_core_pkg::*;
#(
  parameter int LOAD_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  letc_core_lsu_if.slave  bus
);

  localparam int CW = $clog2(LOAD_LATENCY + 1);

  lsu_state_e  state;
  lsu_req_t    req_q;
  logic [CW-1:0] cnt;

  lsu_size_e   a_size;
  logic [1:0]  a_offset;
  logic        a_unsigned;
  logic [31:0] a_wdata;
  logic [31:0] a_store_data;
  logic [3:0]  a_store_be;
  logic [31:0] a_load_result;
  logic        a_misaligned;

  // While idle the lane logic looks at the incoming request; afterwards at the latched one.
  always_comb begin
    if (state == IDLE) begin
      a_size     = lsu_size_e'(bus.req_size);
      a_offset   = bus.req_addr[1:0];
      a_unsigned = bus.req_unsigned;
      a_wdata    = bus.req_wdata;
    end else begin
      a_size     = req_q.size;
      a_offset   = req_q.addr[1:0];
      a_unsigned = req_q.is_unsigned;
      a_wdata    = req_q.wdata;
    end
  end

  letc_core_lsu_align u_align (
    .size        (a_size),
    .offset      (a_offset),
    .is_unsigned (a_unsigned),
    .wdata       (a_wdata),
    .load_word   (bus.dmss_load_data),
    .store_data  (a_store_data),
    .store_be    (a_store_be),
    .load_result (a_load_result),
    .misaligned  (a_misaligned)
  );

  // Request FSM with all handshake and DMSS outputs registered; pulses default low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= IDLE;
      req_q                <= '0;
      cnt                  <= '0;
      bus.req_ready        <= 1'b0;
      bus.rsp_valid        <= 1'b0;
      bus.rsp_data         <= '0;
      bus.rsp_misaligned   <= 1'b0;
      bus.dmss_load_valid  <= 1'b0;
      bus.dmss_load_addr   <= '0;
      bus.dmss_store_valid <= 1'b0;
      bus.dmss_store_addr  <= '0;
      bus.dmss_store_data  <= '0;
      bus.dmss_store_be    <= '0;
    end else begin
      bus.rsp_valid        <= 1'b0;
      bus.rsp_data         <= '0;
      bus.rsp_misaligned   <= 1'b0;
      bus.dmss_load_valid  <= 1'b0;
      bus.dmss_store_valid <= 1'b0;
      bus.dmss_store_addr  <= '0;
      bus.dmss_store_data  <= '0;
      bus.dmss_store_be    <= '0;
      unique case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready     <= 1'b0;
            req_q.is_store    <= bus.req_is_store;
            req_q.size        <= lsu_size_e'(bus.req_size);
            req_q.is_unsigned <= bus.req_unsigned;
            req_q.addr        <= bus.req_addr;
            req_q.wdata       <= bus.req_wdata;
            if (a_misaligned) begin
              state              <= RESP;
              bus.rsp_valid      <= 1'b1;
              bus.rsp_misaligned <= 1'b1;
            end else if (bus.req_is_store) begin
              state                <= ST_ISSUE;
              bus.rsp_valid        <= 1'b1;
              bus.dmss_store_valid <= 1'b1;
              bus.dmss_store_addr  <= lsu_word_addr(bus.req_addr);
              bus.dmss_store_data  <= a_store_data;
              bus.dmss_store_be    <= a_store_be;
            end else begin
              state               <= LD_ISSUE;
              bus.dmss_load_valid <= 1'b1;
              bus.dmss_load_addr  <= lsu_word_addr(bus.req_addr);
            end
          end
        end
        LD_ISSUE: begin
          state              <= LD_WAIT;
          cnt                <= CW'(LOAD_LATENCY - 1);
          bus.dmss_load_addr <= lsu_word_addr(req_q.addr);
        end
        LD_WAIT: begin
          if (cnt == '0) begin
            state              <= RESP;
            bus.rsp_valid      <= 1'b1;
            bus.rsp_data       <= req_q.is_store ? '0 : a_load_result;
            bus.dmss_load_addr <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
        ST_ISSUE: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
